// File: rtl/imm_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_pkg : opcodes, format codes and decode record for imm_gen    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam int unsigned IMM_MAX_W = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_Z    = 3'd7
  } fmt_e;

  // Immediate is carried at the widest XLEN; users keep the low XLEN bits.
  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    fmt_e                 fmt;
    logic                 illegal;
  } dec_t;

  function automatic logic [IMM_MAX_W-1:0] sext(input logic [IMM_MAX_W-1:0] v,
                                                input int unsigned       width);
    logic [IMM_MAX_W-1:0] r;
    r = v << (IMM_MAX_W - width);
    return IMM_MAX_W'($signed(r) >>> (IMM_MAX_W - width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_if : instruction-in / decoded-entry-out handshake bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface imm_gen_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) ();
  import imm_gen_pkg::*;

  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     instr_o;
  logic [PC_W-1:0] pc_o;
  logic [XLEN-1:0] imm_o;
  fmt_e            fmt_o;
  logic            illegal_o;

  modport slave (
    input  in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, pc_o, imm_o, fmt_o, illegal_o
  );

  modport master (
    output in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, pc_o, imm_o, fmt_o, illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_decode : combinational opcode -> immediate/format/illegal decode |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  localparam bit IS_RV32 = (XLEN == 32);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       shift_f3;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    dec_o = '0;
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_JALR: begin
        dec_o.fmt = FMT_I;
        dec_o.imm = sext({52'b0, instr_i[31:20]}, 12);
      end
      OPC_OP_IMM: begin
        dec_o.fmt = FMT_I;
        if (!shift_f3) begin
          dec_o.imm = sext({52'b0, instr_i[31:20]}, 12);
        end else if (IS_RV32) begin
          dec_o.imm     = {59'b0, instr_i[24:20]};
          dec_o.illegal = instr_i[25];
        end else begin
          dec_o.imm = {58'b0, instr_i[25:20]};
        end
      end
      OPC_OP_IMM_32: begin
        // Word shifts only have a 5-bit shamt, on either XLEN.
        dec_o.fmt = FMT_I;
        if (shift_f3) begin
          dec_o.imm     = {59'b0, instr_i[24:20]};
          dec_o.illegal = instr_i[25];
        end else begin
          dec_o.imm = sext({52'b0, instr_i[31:20]}, 12);
        end
        dec_o.illegal = dec_o.illegal | IS_RV32;
      end
      OPC_STORE: begin
        dec_o.fmt = FMT_S;
        dec_o.imm = sext({52'b0, instr_i[31:25], instr_i[11:7]}, 12);
      end
      OPC_BRANCH: begin
        dec_o.fmt = FMT_B;
        dec_o.imm = sext({51'b0, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0}, 13);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_o.fmt = FMT_U;
        dec_o.imm = sext({32'b0, instr_i[31:12], 12'b0}, 32);
      end
      OPC_JAL: begin
        dec_o.fmt = FMT_J;
        dec_o.imm = sext({43'b0, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0}, 21);
      end
      OPC_OP: begin
        dec_o.fmt = FMT_R;
      end
      OPC_OP_32: begin
        dec_o.fmt     = FMT_R;
        dec_o.illegal = IS_RV32;
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          dec_o.fmt = FMT_Z;
          dec_o.imm = {59'b0, instr_i[19:15]};
        end
      end
      default: begin
        dec_o.illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_pipe : registered immediate generator with 2-entry skid      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  imm_gen_if.slave  bus
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  dec_t   dec;
  entry_t in_entry;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (bus.instr_i),
    .dec_o   (dec)
  );

  generate
    if (XLEN < 64) begin : g_imm_hi
      logic unused_imm_hi;
      assign unused_imm_hi = ^dec.imm[IMM_MAX_W-1:XLEN];
    end
  endgenerate

  always_comb begin
    in_entry.instr   = bus.instr_i;
    in_entry.pc      = bus.pc_i;
    in_entry.imm     = dec.imm[XLEN-1:0];
    in_entry.fmt     = dec.fmt;
    in_entry.illegal = dec.illegal;
  end

  assign accept = bus.in_valid_i && !skid_valid_q;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (bus.out_ready_i) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || bus.out_ready_i) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Ready comes straight from the skid flag, never from out_ready_i.
  assign bus.in_ready_o  = !skid_valid_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.instr_o     = out_q.instr;
  assign bus.pc_o        = out_q.pc;
  assign bus.imm_o       = out_q.imm;
  assign bus.fmt_o       = out_q.fmt;
  assign bus.illegal_o   = out_q.illegal;

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It takes one instruction per cycle over a valid/ready handshake and decodes the full 7-bit opcode. It emits the sign- or zero-extended immediate at XLEN width, a format code and an illegal flag, with a 2-entry skid buffer. It sits between the fetch/IF-ID register and the register-file read/control logic, and supports RV32I and RV64I.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
PC_W, 32, width of the PC carried alongside the instruction.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous pipeline flush
in_valid_i  in  1  instruction valid
in_ready_o  out  1  block can accept this cycle
instr_i  in  32  instruction word
pc_i  in  PC_W  instruction PC
out_valid_o  out  1  decoded entry valid
out_ready_i  in  1  consumer accepts
instr_o  out  32  instruction passthrough
pc_o  out  PC_W  PC passthrough
imm_o  out  XLEN  immediate
fmt_o  out  3  format: 0 NONE, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J, 7 Z(csr zimm)
illegal_o  out  1  unsupported or malformed opcode

Behaviour:
- Reset (rst_ni low, asynchronous):
  - out_valid_o=0, skid valid=0, in_ready_o=1.
  - imm_o=0, fmt_o=0, illegal_o=0, instr_o=0, pc_o=0.
- Decode is combinational on the input side. Registers hold decoded results. Latency is 1 cycle from accept to out_valid_o. Throughput is 1 per cycle.
- Opcode map, instr[6:0]:
  - 0000011 LOAD, 0001111 MISC-MEM, 1100111 JALR: I-type, sign-extend instr[31:20].
  - 0010011 OP-IMM, funct3 001/101: shift form, imm = zero-extended shamt.
    - XLEN=32: shamt is instr[24:20]; instr[25]=1 sets illegal.
    - XLEN=64: shamt is instr[25:20].
  - 0010011 OP-IMM, other funct3: I-type, sign-extend instr[31:20].
  - 0011011 OP-IMM-32: I-type, same shift rule with 5-bit shamt. Illegal when XLEN=32.
  - 0100011 STORE: S-type.
  - 1100011 BRANCH: B-type, bit 0 = 0.
  - 0110111 LUI, 0010111 AUIPC: U-type, {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - 1101111 JAL: J-type, bit 0 = 0.
  - 0110011 OP: R, imm=0. 0111011 OP-32: R, illegal when XLEN=32.
  - 1110011 SYSTEM with funct3[2]=1: Z, imm = zero-extended instr[19:15].
  - 1110011 SYSTEM, other funct3: NONE, imm=0.
  - Any other opcode, or instr[1:0]!=11: NONE, imm=0, illegal=1.
- Illegal entries still flow through the handshake; only the flag marks them.
- Immediates are never X; non-immediate formats drive 0.
- in_ready_o = NOT skid_valid, taken straight from a register with no combinational path from out_ready_i.
- Per-cycle update, evaluated in priority order:
  - flush_i=1: both valids cleared at the edge. The input presented that cycle is dropped even if in_valid_i&&in_ready_o. Data registers are don't-care.
  - Skid valid and out_ready_i: output register <= skid, skid cleared.
  - Skid valid and !out_ready_i: hold both.
  - Skid empty, input accepted, and (!out_valid or out_ready_i): output register <= decode(input), out_valid=1.
  - Skid empty, input accepted, out_valid and !out_ready_i: skid <= decode(input), skid valid=1.
  - No input accepted and out_ready_i: out_valid=0.
- Output data is stable while out_valid_o && !out_ready_i.
- Order is strictly preserved. No entry is lost or duplicated.
- Reset mid-transfer drops all in-flight entries.

Decomposition:
- Package imm_gen_pkg holds:
  - opcode localparams (7-bit);
  - fmt_e enum (3-bit, encoding above);
  - struct dec_t {imm, fmt, illegal}, parametrised by XLEN via a function argument width.
- One combinational sub-module, imm_decode (instr + XLEN -> dec_t), instantiated once on the input side.
- The skid/handshake logic stays in imm_gen_pipe.

Test Plan:
1. XLEN=32, ADDI 0xFFF00093 with out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=I, illegal=0. CSRRWI 0x300FD073 -> imm=0x0000001F, fmt=Z.
2. BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, fmt=B. JAL 0x0000006F -> imm=0, fmt=J.
3. XLEN=64, LUI 0x800002B7 -> imm=0xFFFFFFFF80000000, fmt=U. SLLI shamt 32 (0x02009093) -> imm=0x20, illegal=0. Same word with XLEN=32 -> illegal=1.
4. Hold out_ready=0 and present A, B, C back-to-back:
   - A lands in the output register and B in the skid.
   - in_ready drops after B; C is held by the source.
   - Raise out_ready: A, B, C emerge in order on consecutive cycles, none lost or duplicated.
5. Opcode 0x7F and instr[1:0]=00 words -> illegal=1, fmt=NONE, imm=0, handshake completes normally.
6. With output and skid both full, pulse flush_i while in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears. Repeat with rst_ni asserted mid-cycle -> all outputs zero immediately (asynchronous).
